// File: rtl/terminal_counter.sv
// -----------------------------------------------------------------------------
// terminal_counter
//
// Free-running, enable-gated modulo counter. It produces a one-cycle
// terminal-count strobe (tc) every `cmp` enabled clock cycles. A typical use
// is as a rate tick generator, for example a sample-rate strobe with
// cmp = CLK_FREQ / SAMPLE_FREQ.
//
// Parameters:
//   WIDTH   bit width of cmp and out (1..64), default 32
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   synchronous, active-low reset (clears out, forces tc low)
//   clr     in   synchronous clear, only present with TERMINAL_COUNTER_CLR_EN
//   enable  in   count enable; the counter advances only while high
//   cmp     in   period in enabled cycles, unsigned; 0 behaves like 1
//   tc      out  combinational strobe, high in the enabled cycle that wraps
//   out     out  registered current count
//
// Optional feature (macro TERMINAL_COUNTER_CLR_EN):
//   Adds `clr`, a synchronous clear ranked below rst_n and above enable.
//   While clr is high tc is held low and out returns to 0 at the edge.
//
// Strobe semantics: tc is a single-cycle qualifier, not a handshake. It is
// valid only in the cycle it is high, there is no ready/back-pressure, and
// a consumer must sample it on the same rising edge that wraps the counter.
// -----------------------------------------------------------------------------
module terminal_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef TERMINAL_COUNTER_CLR_EN
    input  logic             clr,
`endif
    input  logic             enable,
    input  logic [WIDTH-1:0] cmp,
    output logic             tc,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] last_count;
    logic             term;
    logic             clr_int;

`ifdef TERMINAL_COUNTER_CLR_EN
    assign clr_int = clr;
`else
    assign clr_int = 1'b0;
`endif

    // Highest count value of the period. cmp == 0 is treated as cmp == 1,
    // so both give a last count of 0 and the counter never leaves 0.
    always_comb begin
        if (cmp == '0) begin
            last_count = '0;
        end else begin
            last_count = cmp - WIDTH'(1);
        end
    end

    // ">=" rather than "==": if cmp shrinks below the current count the
    // next enabled cycle wraps at once instead of running to 2^WIDTH.
    assign term = (out >= last_count);

    assign tc = rst_n & ~clr_int & enable & term;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
        end else if (clr_int) begin
            out <= '0;
        end else if (enable) begin
            if (term) begin
                out <= '0;
            end else begin
                out <= out + WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_terminal_counter.sv
// -----------------------------------------------------------------------------
// tb_terminal_counter
//
// Drives terminal_counter (WIDTH = 8) with directed sequences followed by
// randomized traffic. A reference model tracks the number of enabled cycles
// elapsed since the last wrap and predicts {tc, out} for every driven cycle;
// predictions are queued and a separate monitor compares them on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_terminal_counter;

    localparam int W = 8;

`ifdef TERMINAL_COUNTER_CLR_EN
    localparam bit HAS_CLR = 1'b1;
`else
    localparam bit HAS_CLR = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] cmp = '0;
    logic         clr = 1'b0;
    logic         tc;
    logic [W-1:0] out;

    always #5 clk = ~clk;

    terminal_counter #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef TERMINAL_COUNTER_CLR_EN
        .clr    (clr),
`endif
        .enable (enable),
        .cmp    (cmp),
        .tc     (tc),
        .out    (out)
    );

    // ---------------- scoreboard ----------------
    logic [W:0] exp_q[$];
    string      name_q[$];
    int         vectors = 0;
    int         miscompares = 0;

    // Reference model: phase = enabled cycles since the last wrap.
    longint     phase = 0;

    task automatic model_cycle(input logic r, input logic e, input logic [W-1:0] c,
                               input logic k, input string nm);
        longint period;
        bit     last;
        bit     exp_tc;
        logic [W-1:0] exp_out;
        period  = (c == 0) ? 1 : longint'(c);
        last    = (phase >= period - 1);
        exp_tc  = r && !k && e && last;
        exp_out = W'(phase);
        exp_q.push_back({exp_tc, exp_out});
        name_q.push_back(nm);
        if (!r || k)      phase = 0;
        else if (e)       phase = last ? 0 : phase + 1;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r, input logic e, input logic [W-1:0] c,
                         input logic k, input string nm);
        logic k_eff;
        k_eff = HAS_CLR ? k : 1'b0;
        @(posedge clk);
        #1;
        rst_n  = r;
        enable = e;
        cmp    = c;
        clr    = k_eff;
        model_cycle(r, e, c, k_eff, nm);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W:0] exp_v;
            string      nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            vectors++;
            if ({tc, out} !== exp_v) begin
                miscompares++;
                $display("FAIL %s: got tc=%0b out=%0d, expected tc=%0b out=%0d",
                         nm, tc, out, exp_v[W], exp_v[W-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cur_cmp;
        // Unchecked power-on reset so out is defined before any comparison.
        rst_n = 1'b0;
        enable = 1'b1;
        cmp = W'(5);
        repeat (2) @(posedge clk);
        phase = 0;

        // Reset held with enable high.
        repeat (3) drive(1'b0, 1'b1, W'(5), 1'b0, "reset_hold");

        // Basic period, cmp = 4.
        repeat (12) drive(1'b1, 1'b1, W'(4), 1'b0, "period_cmp4");

        // Enable gating, cmp = 5: pause at out = 2.
        drive(1'b0, 1'b1, W'(5), 1'b0, "gate_reset");
        repeat (2) drive(1'b1, 1'b1, W'(5), 1'b0, "gate_run");
        repeat (4) drive(1'b1, 1'b0, W'(5), 1'b0, "gate_pause");
        repeat (6) drive(1'b1, 1'b1, W'(5), 1'b0, "gate_resume");

        // Degenerate cmp values.
        repeat (4) drive(1'b1, 1'b1, W'(0), 1'b0, "cmp0");
        repeat (4) drive(1'b1, 1'b1, W'(1), 1'b0, "cmp1");
        repeat (2) drive(1'b1, 1'b0, W'(1), 1'b0, "cmp1_disabled");

        // cmp shrink from 10 to 3 at out = 7.
        drive(1'b0, 1'b1, W'(10), 1'b0, "shrink_reset");
        repeat (7) drive(1'b1, 1'b1, W'(10), 1'b0, "shrink_count");
        repeat (7) drive(1'b1, 1'b1, W'(3), 1'b0, "shrink_after");

        // cmp grow from 3 to 8 mid-count.
        repeat (1) drive(1'b1, 1'b1, W'(3), 1'b0, "grow_before");
        repeat (10) drive(1'b1, 1'b1, W'(8), 1'b0, "grow_after");

        // Maximum period for this width.
        drive(1'b0, 1'b1, W'(255), 1'b0, "max_reset");
        repeat (260) drive(1'b1, 1'b1, W'(255), 1'b0, "max_period");

        // Reset mid-count.
        drive(1'b1, 1'b1, W'(6), 1'b0, "midreset_run");
        drive(1'b0, 1'b1, W'(6), 1'b0, "midreset");
        repeat (8) drive(1'b1, 1'b1, W'(6), 1'b0, "midreset_after");

        if (HAS_CLR) begin
            drive(1'b0, 1'b1, W'(6), 1'b0, "clr_reset");
            repeat (4) drive(1'b1, 1'b1, W'(6), 1'b0, "clr_count");
            drive(1'b1, 1'b1, W'(6), 1'b1, "clr_pulse");
            repeat (8) drive(1'b1, 1'b1, W'(6), 1'b0, "clr_after");
        end

        // Randomized traffic.
        cur_cmp = 5;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) cur_cmp = $urandom_range(0, 12);
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  W'(cur_cmp),
                  ($urandom_range(0, 49) == 0),
                  "random");
        end

        // Let the monitor drain, then confirm nothing was left unchecked.
        repeat (3) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
